// File: rtl/cam_pixel_pack_writer.sv
// cam_pixel_pack_writer
// Packs an 8-bit sop/eop framed camera pixel stream into little-endian 32-bit
// words and writes them into a single-port pixel memory over Avalon-MM slave
// signals. Software arms one frame at a time with a start pulse.
// Optional build macro CAM_FRAME_CNT_EN adds a 16-bit frame_count output.
module cam_pixel_pack_writer #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DEPTH  = 4096,
   parameter int unsigned CNT_W  = 13
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  max_words,
   input  logic [7:0]        pix_data,
   input  logic              pix_valid,
   input  logic              pix_sop,
   input  logic              pix_eop,
   output logic              pix_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   output logic              busy,
   output logic              frame_done,
   output logic [CNT_W-1:0]  words_written,
   output logic              overflow,
`ifdef CAM_FRAME_CNT_EN
   output logic [15:0]       frame_count,
`endif
   output logic              sop_err
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StWaitSop = 2'd1;
   localparam logic [1:0] StCapture = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  max_q, max_d;
   logic [1:0]        lane_q, lane_d;
   logic [23:0]       pack_q, pack_d;
   logic [CNT_W-1:0]  words_q, words_d;
   logic              ovf_q, ovf_d;
   logic              sop_err_q, sop_err_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              clken_q, clken_d;
   logic              frame_done_q, frame_done_d;
`ifdef CAM_FRAME_CNT_EN
   logic [15:0]       frame_count_q, frame_count_d;
`endif

   // Per-beat working values; a mid-frame sop overrides the stored lane/pack/count.
   logic              take;
   logic [1:0]        cur_lane;
   logic [23:0]       cur_pack;
   logic [CNT_W-1:0]  cur_cnt;
   logic [31:0]       word;
   logic [3:0]        lane_be;
   logic [31:0]       addr_sum;

   // Next-state: arming, pixel packing, word emission, limit and framing checks.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      max_d        = max_q;
      lane_d       = lane_q;
      pack_d       = pack_q;
      words_d      = words_q;
      ovf_d        = ovf_q;
      sop_err_d    = sop_err_q;
      mem_write_d  = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      clken_d      = 1'b1;
      frame_done_d = 1'b0;
      take         = 1'b0;
      cur_lane     = lane_q;
      cur_pack     = pack_q;
      cur_cnt      = words_q;
      word         = '0;
      lane_be      = '0;
      addr_sum     = '0;

      case (state_q)
         StIdle: begin
            if (start) begin
               base_d    = base_addr;
               max_d     = max_words;
               words_d   = '0;
               ovf_d     = 1'b0;
               sop_err_d = 1'b0;
               lane_d    = '0;
               pack_d    = '0;
               state_d   = StWaitSop;
            end
         end
         StWaitSop: take = pix_valid & pix_sop;
         StCapture: take = pix_valid;
         default:   state_d = StIdle;
      endcase

      if (take) begin
         if (pix_sop) begin
            // A sop inside a frame throws away the partial word and restarts at base.
            if (state_q == StCapture) begin
               sop_err_d = 1'b1;
            end
            cur_lane = 2'd0;
            cur_pack = '0;
            cur_cnt  = '0;
            state_d  = StCapture;
         end

         word = {8'h00, cur_pack};
         case (cur_lane)
            2'd0: begin word[7:0]   = pix_data; lane_be = 4'b0001; end
            2'd1: begin word[15:8]  = pix_data; lane_be = 4'b0011; end
            2'd2: begin word[23:16] = pix_data; lane_be = 4'b0111; end
            default: begin word[31:24] = pix_data; lane_be = 4'b1111; end
         endcase

         if ((cur_lane == 2'd3) || pix_eop) begin
            if (cur_cnt < max_q) begin
               addr_sum    = 32'(base_q) + 32'(cur_cnt);
               addr_d      = ADDR_W'(addr_sum % DEPTH);
               mem_write_d = 1'b1;
               wdata_d     = word;
               be_d        = lane_be;
               cur_cnt     = cur_cnt + CNT_W'(1);
            end else begin
               ovf_d = 1'b1;
            end
            lane_d = 2'd0;
            pack_d = '0;
         end else begin
            lane_d = cur_lane + 2'd1;
            pack_d = word[23:0];
         end
         words_d = cur_cnt;

         if (pix_eop) begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
         end
      end
   end

`ifdef CAM_FRAME_CNT_EN
   // Frame counter wraps naturally at 16 bits.
   always_comb begin
      frame_count_d = frame_count_q;
      if (frame_done_d) begin
         frame_count_d = frame_count_q + 16'd1;
      end
   end
`endif

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         base_q       <= '0;
         max_q        <= '0;
         lane_q       <= '0;
         pack_q       <= '0;
         words_q      <= '0;
         ovf_q        <= 1'b0;
         sop_err_q    <= 1'b0;
         mem_write_q  <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         clken_q      <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef CAM_FRAME_CNT_EN
         frame_count_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         max_q        <= max_d;
         lane_q       <= lane_d;
         pack_q       <= pack_d;
         words_q      <= words_d;
         ovf_q        <= ovf_d;
         sop_err_q    <= sop_err_d;
         mem_write_q  <= mem_write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         clken_q      <= clken_d;
         frame_done_q <= frame_done_d;
`ifdef CAM_FRAME_CNT_EN
         frame_count_q <= frame_count_d;
`endif
      end
   end

   // The sensor is never back-pressured.
   assign pix_ready      = 1'b1;
   assign mem_address    = addr_q;
   assign mem_byteenable = be_q;
   assign mem_chipselect = mem_write_q;
   assign mem_write      = mem_write_q;
   assign mem_writedata  = wdata_q;
   assign mem_clken      = clken_q;
   assign busy           = (state_q != StIdle);
   assign frame_done     = frame_done_q;
   assign words_written  = words_q;
   assign overflow       = ovf_q;
   assign sop_err        = sop_err_q;
`ifdef CAM_FRAME_CNT_EN
   assign frame_count    = frame_count_q;
`endif

endmodule

// File: tb/tb_cam_pixel_pack_writer.sv
// tb_cam_pixel_pack_writer
// Drives directed and random frames; expected writes come from a chunking
// model of the pixel list (groups of four pixels after the last sop).
module tb_cam_pixel_pack_writer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [11:0] base_addr;
   logic [12:0] max_words;
   logic [7:0]  pix_data;
   logic        pix_valid, pix_sop, pix_eop;
   logic        pix_ready;
   logic [11:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata;
   logic        busy, frame_done, overflow, sop_err;
   logic [12:0] words_written;
`ifdef CAM_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   cam_pixel_pack_writer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .base_addr      (base_addr),
      .max_words      (max_words),
      .pix_data       (pix_data),
      .pix_valid      (pix_valid),
      .pix_sop        (pix_sop),
      .pix_eop        (pix_eop),
      .pix_ready      (pix_ready),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .busy           (busy),
      .frame_done     (frame_done),
      .words_written  (words_written),
      .overflow       (overflow),
`ifdef CAM_FRAME_CNT_EN
      .frame_count    (frame_count),
`endif
      .sop_err        (sop_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observed writes and frame_done events, sampled mid-cycle.
   logic [11:0] oa[$];
   logic [31:0] od[$];
   logic [3:0]  ob[$];
   int          oc[$];
   int          done_cnt = 0;
   logic        done_w   = 1'b0;
   int          cs_bad   = 0;

   always @(negedge clk) begin
      if (mem_chipselect !== mem_write) cs_bad++;
      if (mem_write === 1'b1) begin
         oa.push_back(mem_address);
         od.push_back(mem_writedata);
         ob.push_back(mem_byteenable);
         oc.push_back(cyc);
      end
      if (frame_done === 1'b1) begin
         done_cnt++;
         done_w = mem_write;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Beat list for the next frame.
   logic [7:0] bd[$];
   bit         bs[$];
   bit         bq_e[$];
   int         bg[$];

   task automatic add_beat(input logic [7:0] d, input bit s, input bit e, input int g);
      bd.push_back(d);
      bs.push_back(s);
      bq_e.push_back(e);
      bg.push_back(g);
   endtask

   task automatic clear_beats();
      bd.delete();
      bs.delete();
      bq_e.delete();
      bg.delete();
   endtask

   task automatic send(input logic [7:0] d, input bit s, input bit e, input int gap);
      pix_data  = d;
      pix_sop   = s;
      pix_eop   = e;
      pix_valid = 1'b1;
      @(posedge clk); #1;
      pix_valid = 1'b0;
      pix_sop   = 1'b0;
      pix_eop   = 1'b0;
      pix_data  = 8'($urandom);
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   // Reference model state.
   logic [7:0]  m_seg[$];
   logic [11:0] m_base;
   logic [12:0] m_max;
   logic [11:0] ea[$];
   logic [31:0] ed[$];
   logic [3:0]  eb[$];
   int          el[$];
   bit          m_ovf;
   int          m_words;
   bit          m_dw;
   int          m_nsop;
   int          exp_frames = 0;

   // Split one segment into 4-pixel chunks; earlier segments lose their partial tail.
   task automatic model_flush(input bit final_seg);
      int nch;
      nch = final_seg ? (m_seg.size() + 3) / 4 : m_seg.size() / 4;
      for (int c = 0; c < nch; c++) begin
         int          len;
         logic [31:0] w;
         len = m_seg.size() - 4 * c;
         if (len > 4) len = 4;
         w = 32'h0;
         for (int k = 0; k < len; k++) w = w | (32'(m_seg[4 * c + k]) << (8 * k));
         if (c < int'(m_max)) begin
            ea.push_back(12'((int'(m_base) + c) % 4096));
            ed.push_back(w);
            eb.push_back(4'((1 << len) - 1));
            el.push_back(len);
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (final_seg) begin
         m_words = (nch < int'(m_max)) ? nch : int'(m_max);
         m_dw    = (nch <= int'(m_max));
      end
   endtask

   task automatic run_frame(input logic [11:0] base, input logic [12:0] maxw);
      bit started;
      bit gapless;
      int n;
      m_base = base;
      m_max  = maxw;
      ea.delete(); ed.delete(); eb.delete(); el.delete(); m_seg.delete();
      m_ovf = 1'b0; m_words = 0; m_dw = 1'b0; m_nsop = 0;
      started = 1'b0;
      gapless = 1'b1;
      for (int i = 0; i < bd.size(); i++) begin
         if (bg[i] != 0) gapless = 1'b0;
         if (!started && !bs[i]) continue;
         if (bs[i]) begin
            if (started) model_flush(1'b0);
            started = 1'b1;
            m_nsop++;
            m_seg.delete();
         end
         m_seg.push_back(bd[i]);
         if (bq_e[i]) break;
      end
      model_flush(1'b1);

      base_addr = base;
      max_words = maxw;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = 12'($urandom);
      max_words = 13'($urandom);
      chk("busy_armed", busy, 1);
      oa.delete(); od.delete(); ob.delete(); oc.delete();
      done_cnt = 0;
      for (int i = 0; i < bd.size(); i++) send(bd[i], bs[i], bq_e[i], bg[i]);
      repeat (3) begin @(posedge clk); #1; end
      exp_frames++;

      chk("nwr", oa.size(), ea.size());
      n = (oa.size() < ea.size()) ? oa.size() : ea.size();
      for (int k = 0; k < n; k++) begin
         chk("wr_addr", oa[k], ea[k]);
         chk("wr_data", od[k], ed[k]);
         chk("wr_be", ob[k], eb[k]);
      end
      if (gapless && m_nsop == 1 && oa.size() == ea.size()) begin
         for (int k = 1; k < oc.size(); k++) chk("wr_gap", oc[k] - oc[k - 1], el[k]);
      end
      chk("done_cnt", done_cnt, 1);
      chk("done_with_wr", done_w, m_dw);
      chk("words", words_written, m_words);
      chk("ovf", overflow, m_ovf);
      chk("sop_err", sop_err, (m_nsop > 1));
      chk("busy_end", busy, 0);
   endtask

   task automatic build_random();
      int  junk, n, sp;
      bit  gappy;
      clear_beats();
      junk  = $urandom_range(0, 2);
      gappy = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < junk; i++) add_beat(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 0);
      n  = $urandom_range(1, 24);
      sp = (n > 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : -1;
      for (int i = 0; i < n; i++)
         add_beat(8'($urandom), (i == 0) || (i == sp), (i == n - 1),
                  gappy ? $urandom_range(0, 2) : 0);
   endtask

   initial begin
      logic [12:0] rmax;
      logic [11:0] rbase;
      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      max_words = '0;
      pix_data  = '0;
      pix_valid = 1'b0;
      pix_sop   = 1'b0;
      pix_eop   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_write", mem_write, 0);
      chk("rst_clken", mem_clken, 0);
      chk("rst_busy", busy, 0);
      chk("rst_words", words_written, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_sop_err", sop_err, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_addr", mem_address, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("clken_after_rst", mem_clken, 1);

      // Idle stream without start: everything discarded.
      oa.delete();
      for (int i = 0; i < 8; i++) begin
         chk("idle_ready", pix_ready, 1);
         send(8'($urandom), (i == 0), (i == 7), 0);
      end
      chk("idle_nwr", oa.size(), 0);
      chk("idle_busy", busy, 0);

      clear_beats();
      for (int i = 0; i < 8; i++) add_beat(8'(i + 1), (i == 0), (i == 7), 0);
      run_frame(12'h010, 13'd16);

      clear_beats();
      for (int i = 0; i < 6; i++) add_beat(8'(8'hA0 + i), (i == 0), (i == 5), 0);
      run_frame(12'h020, 13'd16);

      clear_beats();
      for (int i = 0; i < 12; i++) add_beat(8'($urandom), (i == 0), (i == 11), 0);
      run_frame(12'hFFE, 13'd16);

      clear_beats();
      for (int i = 0; i < 8; i++) add_beat(8'($urandom), (i == 0), (i == 7), 0);
      run_frame(12'h100, 13'd1);

      clear_beats();
      for (int i = 0; i < 5; i++) add_beat(8'($urandom), (i == 0), (i == 4), 0);
      run_frame(12'h200, 13'd0);

      clear_beats();
      for (int i = 0; i < 3; i++) add_beat(8'($urandom), (i == 0), 1'b0, 0);
      for (int i = 0; i < 4; i++) add_beat(8'($urandom), (i == 0), (i == 3), 0);
      run_frame(12'h300, 13'd16);

      clear_beats();
      add_beat(8'h5A, 1'b1, 1'b1, 0);
      run_frame(12'h040, 13'd4);

      for (int f = 0; f < 20; f++) begin
         build_random();
         rbase = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + $urandom_range(0, 3))
                                             : 12'($urandom);
         rmax  = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 3))
                                             : 13'($urandom_range(0, 4096));
         run_frame(rbase, rmax);
      end

`ifdef CAM_FRAME_CNT_EN
      chk("frame_count", frame_count, exp_frames);
`endif

      // Reset in the middle of a frame: no writes afterwards.
      start     = 1'b1;
      base_addr = 12'h050;
      max_words = 13'd16;
      @(posedge clk); #1;
      start = 1'b0;
      send(8'h11, 1'b1, 1'b0, 0);
      send(8'h22, 1'b0, 1'b0, 0);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_write", mem_write, 0);
      chk("midrst_clken", mem_clken, 0);
      reset_n = 1'b1;
      oa.delete();
      for (int i = 0; i < 7; i++) send(8'($urandom), 1'b0, (i == 6), 0);
      repeat (3) begin @(posedge clk); #1; end
      chk("midrst_nwr", oa.size(), 0);
      chk("midrst_busy_end", busy, 0);
      chk("midrst_words", words_written, 0);
`ifdef CAM_FRAME_CNT_EN
      chk("midrst_frame_count", frame_count, 0);
`endif
      chk("cs_follows_write", cs_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cam_pixel_pack_writer.md
Name: cam_pixel_pack_writer

Overview:
- Upstream feeder for the 4096x32 single-port on-chip pixel memory.
- Accepts an 8-bit camera pixel stream with sop/eop framing and packs 4 pixels little-endian into 32-bit words.
- Writes each word through the memory's Avalon-MM slave signals (address, byteenable, chipselect, write, writedata, clken).
- Software arms one frame capture at a time and reads back status.

Parameters:
- ADDR_W, 12, memory word-address width.
- DEPTH, 4096, memory depth in 32-bit words (2**ADDR_W).
- CNT_W, 13, width of word counters (holds 0..DEPTH).

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; arms capture of the next frame.
- base_addr  in  ADDR_W  first word address of the frame; latched on accepted start.
- max_words  in  CNT_W  word limit for the frame; latched on accepted start.
- pix_data  in  8  pixel value.
- pix_valid  in  1  pixel beat valid.
- pix_sop  in  1  first pixel of frame; qualified by pix_valid.
- pix_eop  in  1  last pixel of frame; qualified by pix_valid.
- pix_ready  out  1  beat accepted when pix_valid & pix_ready.
- mem_address  out  ADDR_W  memory word address.
- mem_byteenable  out  4  memory byte lanes.
- mem_chipselect  out  1  memory select.
- mem_write  out  1  memory write strobe.
- mem_writedata  out  32  packed pixel word.
- mem_clken  out  1  memory clock enable.
- busy  out  1  high while state is not IDLE.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- words_written  out  CNT_W  words written in the current/last frame.
- overflow  out  1  sticky: pixels dropped because of the word limit.
- sop_err  out  1  sticky: sop seen mid-frame.

Behaviour:
- Reset (reset_n low at clk edge) sets state IDLE and clears mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata, mem_clken, frame_done, busy, words_written, overflow, sop_err. Internal lane and word counters also clear. After reset, mem_clken is registered 1.
- All memory outputs are registered. mem_chipselect equals mem_write. Each write lasts exactly one cycle; the memory has no waitrequest.
- pix_ready is 1 in every state after reset, so the block never stalls the sensor. Beats outside a capture are discarded.
- States:
  - IDLE: start=1 latches base_addr/max_words, clears words_written/overflow/sop_err and lane count, then goes to WAIT_SOP. start in any other state is ignored.
  - WAIT_SOP: beats without sop are discarded. A beat with sop goes into lane 0 and the state moves to CAPTURE. If that beat also has eop, the frame ends immediately (1-pixel frame).
  - CAPTURE: each accepted beat goes into lane lane_cnt (lane0 = bits 7:0). lane_cnt increments mod 4.
- Word write:
  - When lane 3 fills, or on an eop beat, the packed word is transferred to the output register.
  - The next cycle has mem_write=1, mem_address=(base+word_idx) mod DEPTH, and byteenable = 4'hF for a full word or the filled lanes for a partial one (1 lane→0001, 2→0011, 3→0111).
  - Unfilled lanes of writedata are 0. word_idx and words_written increment with the write.
  - Packing continues in parallel, so back-to-back beats produce one write every 4 cycles with no gaps.
- End of frame:
  - An eop beat triggers the final write in the next cycle.
  - frame_done pulses in the same cycle as that write, then the state returns to IDLE.
- Word limit:
  - A word that would be write number words_written == max_words is dropped: no mem_write, overflow set.
  - Capture still continues until eop; frame_done still pulses at eop even if that write is dropped.
  - max_words=0 drops every word.
- Address wrap: base+word_idx wraps modulo DEPTH, e.g. base 4095 then 0.
- sop during CAPTURE:
  - The partial word is discarded (no write) and sop_err is set.
  - Capture restarts: word_idx=0, words_written=0, and the sop pixel goes into lane 0.
  - overflow is preserved.
- Reset mid-frame: outputs return to reset values the next edge; no further writes occur.

Optional Feature:
- Macro CAM_FRAME_CNT_EN.
- Defined: adds output port frame_count (16 bits), reset 0. It increments on every frame_done pulse and wraps 0xFFFF→0x0000.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle stream: 8 beats with no start → pix_ready=1, no mem_write, busy=0, mem_clken=1 after reset.
- start with base=0x010, max=16; frame of 8 pixels 0x01..0x08 back-to-back → writes 0x04030201 @0x010 and 0x08070605 @0x011, byteenable F, frame_done with 2nd write, words_written=2.
- Frame of 6 pixels 0xA0..0xA5 → full word @base, partial word 0x0000A5A4 with byteenable 0011 @base+1.
- base=0xFFE, 12 pixels → writes at 0xFFE, 0xFFF, 0x000.
- max=1, 8 pixels → single write @base, overflow=1, frame_done at eop, words_written=1.
- 3 pixels then sop mid-frame, then 4 pixels + eop → sop_err=1, one write of the new 4 pixels @base; and reset_n low mid-frame → mem_write stays 0 afterwards.
